// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-latched pending sources, fixed-priority
// arbitration and a four-phase ExtIRQ/ExtlAck handshake with the core.
module ext_irq_ctrl #(
    parameter int NSRC = 4,
    parameter int IDW  = $clog2(NSRC)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] src_evt,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ExtlAck,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] pending,
    output logic [7:0]      drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [NSRC-1:0] prev_evt_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] evt_edge;
    logic            drop_hit;

    function automatic logic [IDW-1:0] lowest_idx(input logic [NSRC-1:0] v);
        lowest_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDW'(i);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        ack_clr  = '0;
        case (state_q)
            S_IDLE: begin
                if (|(pending_q & mask_q)) begin
                    irq_id_d = lowest_idx(pending_q & mask_q);
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (ExtlAck) begin
                    ack_clr = NSRC'(1) << irq_id_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ExtlAck) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ack clear is applied before new edges, so a same-cycle re-trigger of
    // the acked source re-latches without being counted as a drop.
    always_comb begin
        evt_edge   = src_evt & ~prev_evt_q & mask_q;
        pend_clr   = pending_q & ~ack_clr;
        pending_d  = pend_clr | evt_edge;
        drop_hit   = |(evt_edge & pend_clr);
        drop_cnt_d = drop_cnt_q;
        if (drop_hit && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
        mask_d     = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            irq_id_q   <= '0;
            prev_evt_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            irq_id_q   <= irq_id_d;
            prev_evt_q <= src_evt;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ExtIRQ   = (state_q == S_REQ);
    assign irq_id   = ExtIRQ ? irq_id_q : '0;
    assign pending  = pending_q;
    assign drop_cnt = drop_cnt_q;

endmodule
